conv2_filter_unit: RTL and testbench
====================================

// Module: conv2_filter_unit
// PURPOSE
//   One 3x3 convolution filter (single output channel) for the conv2 layer.
//   Computes the dot product of a 3x3 input window with 9 weights, adds a bias,
//   saturates the result and applies ReLU. It is a fully pipelined block with
//   fixed latency. The conv2 layer instantiates many copies (one per filter per
//   mux lane); the parent samples filter_out on a fixed schedule.
// PARAMETERS
//   DW        32  data/weight/bias/output width (signed two's complement)
//   FRAC_BITS 16  fractional bits of the fixed-point format (Q16.16; 1.0 = 32'h0001_0000)
//   RELU_EN   1   1: clamp negative results to 0; 0: pass the signed result through
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   valid_in    in   1       window/weights/bias valid this cycle
//   data_out    in   DW x9   3x3 input window, [0..8] = row-major (r0c0..r2c2)
//   bias        in   DW      per-filter bias, Q16.16
//   weight      in   DW x9   3x3 kernel, same index order as data_out
//   filter_out  out  DW      filter result, Q16.16 (after ReLU when RELU_EN=1)
// BEHAVIOUR
//   - Interface: one clock, clk; asynchronous active-low reset, rst_n.
//   - Reset (async assert, sync use): filter_out=0, all pipeline valids=0,
//     pipeline data regs=0. Reset mid-operation discards all in-flight results.
//   - Inputs are sampled on a rising edge where valid_in=1. data_out, weight and
//     bias are all captured on that same edge. No backpressure is applied.
//   - Throughput: 1 window/cycle; back-to-back valid_in is fully supported.
//   - Pipeline, latency 3 cycles (edge E = capture edge):
//       S1 @E  : p[k] = $signed(data_out[k]) * $signed(weight[k]), 64-bit full
//                product, k=0..8; b = bias sign-extended and shifted left
//                FRAC_BITS; v1<=valid_in
//       S2 @E+1: s0=p0+p1+p2, s1=p3+p4+p5, s2=p6+p7+p8+b (68-bit signed); v2<=v1
//       S3 @E+2: acc = s0+s1+s2; r = acc >>> FRAC_BITS (arithmetic shift,
//                i.e. truncation toward -inf); if v2 then filter_out<=final(r)
//   - All sums use 68-bit accumulators and never overflow internally.
//   - Saturation: if r > 2^31-1 then 32'h7FFF_FFFF; if r < -2^31 then
//     32'h8000_0000; otherwise r[31:0].
//   - ReLU (RELU_EN=1): a saturated value with bit31=1 becomes 0. Exactly zero
//     passes as zero.
//   - filter_out is registered. It holds its last value while no valid result
//     reaches S3. It never changes on a cycle without a completed valid result.
//   - Stages with valid=0 still advance, but their data must not affect
//     filter_out.
// TESTING
//   1 Reset: assert rst_n=0 asynchronously mid-cycle -> filter_out=0 immediately;
//     no update for 3 cycles after release while valid_in=0.
//   2 All data=weight=32'h0001_0000, bias=0, one valid pulse -> filter_out =
//     32'h0009_0000 exactly 3 edges after capture, then held.
//   3 Center only: data[4]=32'h0003_0000 (3.0), weight[4]=32'h0000_8000 (0.5),
//     others 0, bias=32'h0001_0000 -> 32'h0002_8000. With bias=32'hFFFE_0000
//     (-2.0) -> -0.5 -> 0 (RELU_EN=1); 32'hFFFF_8000 when RELU_EN=0.
//   4 Saturation: all data=weight=32'h7FFF_FFFF, bias=32'h7FFF_FFFF ->
//     32'h7FFF_FFFF; data=32'h8000_0000 with weight=32'h7FFF_FFFF, RELU_EN=0 ->
//     32'h8000_0000.
//   5 Streaming: 10 consecutive valid windows with distinct values -> 10
//     consecutive correct outputs, cycle-aligned at latency 3. Then a valid_in
//     gap -> output held.
//   6 Reset mid-pipeline: valid pulse, then rst_n low 1 cycle after capture ->
//     filter_out stays 0; no stale result appears after release.

Source files
------------

// File: rtl/conv2_filter_unit.sv
// Single 3x3 convolution filter: dot product of a window with 9 weights plus bias,
// then Q16.16 scaling, saturation and optional ReLU. Fixed 3-cycle pipeline.
module conv2_filter_unit #(
  parameter int DW        = 32,
  parameter int FRAC_BITS = 16,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [9*DW-1:0] data_out,
  input  logic [DW-1:0]   bias,
  input  logic [9*DW-1:0] weight,
  output logic [DW-1:0]   filter_out
);

  localparam int PW = 2 * DW;
  localparam int AW = PW + 4;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [AW-1:0] ext_prod(input logic signed [PW-1:0] p);
    return {{(AW-PW){p[PW-1]}}, p};
  endfunction

  logic signed [PW-1:0] prod_d [9];
  logic signed [PW-1:0] prod_q [9];
  logic signed [AW-1:0] bias_d, bias_q;
  logic                 v1_q;

  logic signed [AW-1:0] s0_d, s1_d, s2_d;
  logic signed [AW-1:0] s0_q, s1_q, s2_q;
  logic                 v2_q;

  logic signed [AW-1:0] acc_s;
  logic signed [AW-1:0] shr_s;
  logic [DW-1:0]        sat_s;
  logic [DW-1:0]        final_s;
  logic [DW-1:0]        filter_out_d, filter_out_q;

  // Operands are sign-extended to full product width so the multiply is exact.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = $signed({{DW{data_out[k*DW+DW-1]}}, data_out[k*DW +: DW]}) *
                  $signed({{DW{weight[k*DW+DW-1]}}, weight[k*DW +: DW]});
    end
    bias_d = $signed({{(AW-DW){bias[DW-1]}}, bias}) <<< FRAC_BITS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      bias_q <= '0;
      for (int k = 0; k < 9; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      v1_q   <= valid_in;
      bias_q <= bias_d;
      for (int k = 0; k < 9; k++) begin
        prod_q[k] <= prod_d[k];
      end
    end
  end

  always_comb begin
    s0_d = ext_prod(prod_q[0]) + ext_prod(prod_q[1]) + ext_prod(prod_q[2]);
    s1_d = ext_prod(prod_q[3]) + ext_prod(prod_q[4]) + ext_prod(prod_q[5]);
    s2_d = ext_prod(prod_q[6]) + ext_prod(prod_q[7]) + ext_prod(prod_q[8]) + bias_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v2_q <= v1_q;
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Arithmetic shift truncates toward -inf before the result is clamped to DW bits.
  always_comb begin
    acc_s = s0_q + s1_q + s2_q;
    shr_s = acc_s >>> FRAC_BITS;
    if (shr_s > SAT_MAX) begin
      sat_s = {1'b0, {(DW-1){1'b1}}};
    end else if (shr_s < SAT_MIN) begin
      sat_s = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_s = shr_s[DW-1:0];
    end
    if (RELU_EN && sat_s[DW-1]) begin
      final_s = '0;
    end else begin
      final_s = sat_s;
    end
    if (v2_q) begin
      filter_out_d = final_s;
    end else begin
      filter_out_d = filter_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_out_q <= '0;
    end else begin
      filter_out_q <= filter_out_d;
    end
  end

  assign filter_out = filter_out_q;

endmodule

// File: tb/tb_conv2_filter_unit.sv
// Self-checking bench: ReLU and pass-through instances share stimulus; expected
// results go through a scoreboard queue tagged with the edge they must appear on.
module tb_conv2_filter_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [287:0] data_s;
  logic [287:0] weight_s;
  logic [31:0]  bias_s;
  logic [31:0]  out_relu;
  logic [31:0]  out_raw;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  bit mon_en = 1'b0;
  logic [31:0] last_relu = 32'h0;
  logic [31:0] last_raw  = 32'h0;

  typedef struct {
    string        name;
    logic [287:0] data;
    logic [287:0] weight;
    logic [31:0]  bias;
    logic [31:0]  exp_relu;
    logic [31:0]  exp_raw;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp_relu;
    logic [31:0] exp_raw;
    int          due;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  conv2_filter_unit #(.DW(32), .FRAC_BITS(16), .RELU_EN(1'b1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_out(data_s),
    .bias(bias_s), .weight(weight_s), .filter_out(out_relu)
  );

  conv2_filter_unit #(.DW(32), .FRAC_BITS(16), .RELU_EN(1'b0)) u_dut_raw (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_out(data_s),
    .bias(bias_s), .weight(weight_s), .filter_out(out_raw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [287:0] one_at(input int idx, input logic [31:0] v);
    logic [287:0] r;
    r = '0;
    r[idx*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [287:0] fill_all(input logic [31:0] v);
    logic [287:0] r;
    for (int k = 0; k < 9; k++) r[k*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [31:0] rnd_small();
    logic [31:0] v;
    v = ($urandom & 32'h0003_FFFF) - 32'h0002_0000;
    return v;
  endfunction

  // Reference: exact products, wide sum, floor shift, clamp, optional ReLU
  function automatic logic [31:0] model(input logic [287:0] d, input logic [287:0] w,
                                        input logic [31:0] b, input bit relu);
    logic signed [67:0] acc;
    logic signed [67:0] r;
    logic signed [63:0] p;
    logic signed [63:0] a;
    logic signed [63:0] c;
    logic [31:0] s;
    acc = $signed({{36{b[31]}}, b}) * 68'sd65536;
    for (int k = 0; k < 9; k++) begin
      a = $signed({{32{d[k*32+31]}}, d[k*32 +: 32]});
      c = $signed({{32{w[k*32+31]}}, w[k*32 +: 32]});
      p = a * c;
      acc = acc + {{4{p[63]}}, p};
    end
    r = acc >>> 16;
    if (r > 68'sd2147483647)       s = 32'h7FFF_FFFF;
    else if (r < -68'sd2147483648) s = 32'h8000_0000;
    else                           s = r[31:0];
    if (relu && s[31]) s = 32'h0;
    return s;
  endfunction

  task automatic drive(input string nm, input logic [287:0] d, input logic [287:0] w,
                       input logic [31:0] b, input logic [31:0] er, input logic [31:0] ea);
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    data_s   = d;
    weight_s = w;
    bias_s   = b;
    sb.push_back('{nm, er, ea, edge_cnt + 3});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      data_s   = {9{$urandom()}};
      weight_s = {9{$urandom()}};
      bias_s   = $urandom();
    end
  endtask

  task automatic async_reset(input int hold_cycles);
    @(posedge clk);
    #2;
    mon_en   = 1'b0;
    valid_in = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_immediate_relu", out_relu, 32'h0);
    check("rst_immediate_raw", out_raw, 32'h0);
    sb.delete();
    last_relu = 32'h0;
    last_raw  = 32'h0;
    repeat (hold_cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  // Output monitor: compare due results, otherwise require the output to hold
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() != 0 && sb[0].due < edge_cnt) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_%s: got none expected %08h", sb[0].name, sb[0].exp_raw);
        void'(sb.pop_front());
      end
      if (sb.size() != 0 && sb[0].due == edge_cnt) begin
        check({sb[0].name, "_relu"}, out_relu, sb[0].exp_relu);
        check({sb[0].name, "_raw"}, out_raw, sb[0].exp_raw);
        last_relu = sb[0].exp_relu;
        last_raw  = sb[0].exp_raw;
        void'(sb.pop_front());
      end else begin
        check("hold_relu", out_relu, last_relu);
        check("hold_raw", out_raw, last_raw);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [287:0] d;
    logic [287:0] w;
    logic [31:0]  b;

    tbl.push_back('{"ones", fill_all(32'h0001_0000), fill_all(32'h0001_0000), 32'h0, 32'h0009_0000, 32'h0009_0000});
    tbl.push_back('{"center_pos", one_at(4, 32'h0003_0000), one_at(4, 32'h0000_8000), 32'h0001_0000, 32'h0002_8000, 32'h0002_8000});
    tbl.push_back('{"center_neg", one_at(4, 32'h0003_0000), one_at(4, 32'h0000_8000), 32'hFFFE_0000, 32'h0, 32'hFFFF_8000});
    tbl.push_back('{"sat_pos", fill_all(32'h7FFF_FFFF), fill_all(32'h7FFF_FFFF), 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
    tbl.push_back('{"sat_neg", fill_all(32'h8000_0000), fill_all(32'h7FFF_FFFF), 32'h0, 32'h0, 32'h8000_0000});
    tbl.push_back('{"zero", fill_all(32'h0), fill_all(32'h0), 32'h0, 32'h0, 32'h0});
    tbl.push_back('{"trunc_pos", one_at(0, 32'h0000_0001), one_at(0, 32'h0000_0001), 32'h0, 32'h0, 32'h0});
    tbl.push_back('{"trunc_neg", one_at(0, 32'hFFFF_FFFF), one_at(0, 32'h0000_0001), 32'h0, 32'h0, 32'hFFFF_FFFF});
    tbl.push_back('{"max_exact", one_at(0, 32'h7FFF_FFFF), one_at(0, 32'h0001_0000), 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
    tbl.push_back('{"min_exact", one_at(0, 32'h8000_0000), one_at(0, 32'h0001_0000), 32'h0, 32'h0, 32'h8000_0000});
    tbl.push_back('{"bias_only", fill_all(32'h0), fill_all(32'h0), 32'h0003_4000, 32'h0003_4000, 32'h0003_4000});
    tbl.push_back('{"bias_neg", fill_all(32'h0), fill_all(32'h0), 32'hFFFF_0000, 32'h0, 32'hFFFF_0000});
    tbl.push_back('{"mix", one_at(0, 32'h0002_0000) | one_at(8, 32'h0001_4000),
                   one_at(0, 32'hFFFE_8000) | one_at(8, 32'h0004_0000), 32'h0000_4000, 32'h0002_4000, 32'h0002_4000});

    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_s   = '0;
    weight_s = '0;
    bias_s   = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_relu", out_relu, 32'h0);
    check("reset_raw", out_raw, 32'h0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(4);

    // Single pulse then hold, followed by an asynchronous mid-cycle reset
    drive("single_ones", fill_all(32'h0001_0000), fill_all(32'h0001_0000), 32'h0, 32'h0009_0000, 32'h0009_0000);
    idle(6);
    async_reset(2);
    idle(4);

    // Table vectors streamed back-to-back
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].name, tbl[i].data, tbl[i].weight, tbl[i].bias, tbl[i].exp_relu, tbl[i].exp_raw);
    end
    idle(5);

    // Ten distinct random windows back-to-back, then a gap
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 9; k++) begin
        d[k*32 +: 32] = rnd_small();
        w[k*32 +: 32] = rnd_small();
      end
      b = ($urandom & 32'h000F_FFFF) - 32'h0008_0000;
      drive($sformatf("stream%0d", i), d, w, b, model(d, w, b, 1'b1), model(d, w, b, 1'b0));
    end
    idle(6);

    // Reset one cycle after capture must squash the in-flight result
    drive("squashed", fill_all(32'h0001_0000), fill_all(32'h0001_0000), 32'h0, 32'h0009_0000, 32'h0009_0000);
    async_reset(1);
    idle(6);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
